// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, hands words to decode over valid/ready.
// Optional FETCH_PERF_EN adds fetch/flush performance counters.
module fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcsrc,
    input  logic [WIDTH-1:0] branch_pc,
    input  logic [WIDTH-1:0] imm_op,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic [WIDTH-1:0]   sum_c;
    logic [WIDTH-1:0]   target_c;

    // Redirect target is always word aligned
    assign sum_c    = branch_pc + imm_op;
    assign target_c = {sum_c[WIDTH-1:2], 2'b00};

    assign mem_addr    = pc_q;
    assign mem_req     = req_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            instr_pc_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (pcsrc) begin
                    pc_d = target_c;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (pcsrc) begin
                        pc_d    = target_c;
                        state_d = IDLE;
                    end else begin
                        instr_d    = mem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + WIDTH'(4);
                        state_d    = HOLD;
                    end
                end else if (pcsrc) begin
                    pend_d  = target_c;
                    state_d = DRAIN;
                end
            end
            // Keep the in-flight request stable until its ack, then take the latest redirect
            DRAIN: begin
                if (pcsrc) begin
                    pend_d = target_c;
                end
                if (mem_ack) begin
                    pc_d    = pcsrc ? target_c : pend_q;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (pcsrc) begin
                    valid_d = 1'b0;
                    pc_d    = target_c;
                    state_d = IDLE;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == REQ) || (state_d == DRAIN);
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Count accepted transfers and every redirect cycle outside IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == HOLD && instr_ready && !pcsrc) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (pcsrc && (state_q == REQ || state_q == DRAIN || state_q == HOLD)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences, randomized run vs model.
module tb_fetch_ctrl;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, pcsrc, mem_ack, instr_ready;
    logic [W-1:0] branch_pc, imm_op, mem_addr, instr_pc;
    logic         mem_req, instr_valid;
    logic [31:0]  mem_rdata, instr;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_fetch_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.WIDTH(W), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .pcsrc(pcsrc), .branch_pc(branch_pc), .imm_op(imm_op),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, p;
        logic [31:0] bp, im;
        logic        a;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_ipc;
        int unsigned e_fc, e_lc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic p, input logic [31:0] bp, input logic [31:0] im,
                       input logic a, input logic [31:0] rd, input logic rdy,
                       input logic er, input logic ev, input logic [31:0] ea, input logic [31:0] ei,
                       input logic [31:0] eip, input int unsigned efc, input int unsigned elc);
        vec_t v;
        v.r = r; v.p = p; v.bp = bp; v.im = im; v.a = a; v.rd = rd; v.rdy = rdy;
        v.e_req = er; v.e_valid = ev; v.e_addr = ea; v.e_instr = ei; v.e_ipc = eip;
        v.e_fc = efc; v.e_lc = elc;
        vq.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Expected word for an address: the bench memory returns addr ^ 0xA5A5A5A5
    logic [31:0] m_pc, m_pend, m_instr, m_ipc;
    bit          m_busy, m_squash, m_valid;
    int unsigned m_fc, m_lc;

    task automatic model_step();
        logic [31:0] tgt;
        tgt = (branch_pc + imm_op) & 32'hFFFF_FFFC;
        if (!rst) begin
            m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
            m_busy = 0; m_squash = 0; m_valid = 0; m_fc = 0; m_lc = 0;
        end else if (m_valid) begin
            if (pcsrc) begin
                m_lc++; m_valid = 0; m_pc = tgt;
            end else if (instr_ready) begin
                m_fc++; m_valid = 0; m_busy = 1;
            end
        end else if (m_busy && !m_squash) begin
            if (pcsrc) m_lc++;
            if (mem_ack) begin
                m_busy = 0;
                if (pcsrc) m_pc = tgt;
                else begin
                    m_instr = mem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
                end
            end else if (pcsrc) begin
                m_pend = tgt; m_squash = 1;
            end
        end else if (m_busy) begin
            if (pcsrc) begin
                m_lc++; m_pend = tgt;
            end
            if (mem_ack) begin
                m_pc = m_pend; m_busy = 0; m_squash = 0;
            end
        end else begin
            if (pcsrc) m_pc = tgt;
            else m_busy = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        chk("mem_addr", mem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fc);
        chk("perf_flush_cnt", perf_flush_cnt, m_lc);
`endif
    endtask

    task automatic set_in(input logic r, input logic p, input logic [31:0] bp, input logic [31:0] im,
                          input logic a, input logic [31:0] rd, input logic rdy);
        rst = r; pcsrc = p; branch_pc = bp; imm_op = im; mem_ack = a; mem_rdata = rd; instr_ready = rdy;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Streaming, HOLD stall, redirect in REQ with late ack, redirect in HOLD, reset mid-request
        add(0,0,0,0, 0,0,1,            0,0,32'h0,  32'h0,        32'h0, 0,0);
        add(1,0,0,0, 0,0,1,            1,0,32'h0,  32'h0,        32'h0, 0,0);
        add(1,0,0,0, 1,32'hA5A5A5A5,1, 0,1,32'h4,  32'hA5A5A5A5, 32'h0, 0,0);
        add(1,0,0,0, 0,0,1,            1,0,32'h4,  32'hA5A5A5A5, 32'h0, 1,0);
        add(1,0,0,0, 1,32'hA5A5A5A1,1, 0,1,32'h8,  32'hA5A5A5A1, 32'h4, 1,0);
        add(1,0,0,0, 0,0,1,            1,0,32'h8,  32'hA5A5A5A1, 32'h4, 2,0);
        add(1,0,0,0, 1,32'hA5A5A5AD,0, 0,1,32'hC,  32'hA5A5A5AD, 32'h8, 2,0);
        for (int i = 0; i < 5; i++)
            add(1,0,0,0, 0,0,0,        0,1,32'hC,  32'hA5A5A5AD, 32'h8, 2,0);
        add(1,0,0,0, 0,0,1,            1,0,32'hC,  32'hA5A5A5AD, 32'h8, 3,0);
        add(1,1,32'h10,32'h20, 0,0,1,  1,0,32'hC,  32'hA5A5A5AD, 32'h8, 3,1);
        add(1,0,0,0, 0,0,1,            1,0,32'hC,  32'hA5A5A5AD, 32'h8, 3,1);
        add(1,0,0,0, 0,0,1,            1,0,32'hC,  32'hA5A5A5AD, 32'h8, 3,1);
        add(1,0,0,0, 1,32'hDEADBEEF,1, 0,0,32'h30, 32'hA5A5A5AD, 32'h8, 3,1);
        add(1,0,0,0, 0,0,1,            1,0,32'h30, 32'hA5A5A5AD, 32'h8, 3,1);
        add(1,0,0,0, 1,32'hA5A5A595,1, 0,1,32'h34, 32'hA5A5A595, 32'h30, 3,1);
        add(1,1,32'h100,32'hFFFFFFF8, 0,0,1, 0,0,32'hF8, 32'hA5A5A595, 32'h30, 3,2);
        add(1,1,32'h103,32'h0, 0,0,1,  0,0,32'h100,32'hA5A5A595, 32'h30, 3,2);
        add(1,0,0,0, 0,0,1,            1,0,32'h100,32'hA5A5A595, 32'h30, 3,2);
        add(0,0,0,0, 0,0,1,            0,0,32'h0,  32'h0,        32'h0, 0,0);
        add(1,0,0,0, 1,32'h12345678,1, 1,0,32'h0,  32'h0,        32'h0, 0,0);
        add(1,0,0,0, 1,32'hA5A5A5A5,1, 0,1,32'h4,  32'hA5A5A5A5, 32'h0, 0,0);

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].r, vq[i].p, vq[i].bp, vq[i].im, vq[i].a, vq[i].rd, vq[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.mem_req", i), 32'(mem_req), 32'(vq[i].e_req));
            chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(vq[i].e_valid));
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, vq[i].e_addr);
            chk($sformatf("vec%0d.instr", i), instr, vq[i].e_instr);
            chk($sformatf("vec%0d.instr_pc", i), instr_pc, vq[i].e_ipc);
`ifdef FETCH_PERF_EN
            chk($sformatf("vec%0d.perf_fetch", i), perf_fetch_cnt, vq[i].e_fc);
            chk($sformatf("vec%0d.perf_flush", i), perf_flush_cnt, vq[i].e_lc);
`endif
        end

        // PC wrap: fetch at 0xFFFFFFFC, next address is 0
        set_in(0,0,0,0,0,0,1); tick();
        set_in(1,1,32'hFFFFFFFC,32'h0,0,0,1); tick();
        set_in(1,0,0,0,0,0,1); tick();
        set_in(1,0,0,0,1,32'h5A5A5A59,1); tick();
        chk("wrap.mem_addr", mem_addr, 32'h0);
        chk("wrap.instr_pc", instr_pc, 32'hFFFFFFFC);

        // Redirect in DRAIN coinciding with the ack: newest target wins
        set_in(0,0,0,0,0,0,1); tick();
        set_in(1,0,0,0,0,0,1); tick();
        set_in(1,1,32'h200,32'h0,0,0,1); tick();
        set_in(1,1,32'h300,32'h4,1,32'h0,1); tick();
        chk("drain_ack.mem_addr", mem_addr, 32'h304);
        chk("drain_ack.mem_req", 32'(mem_req), 32'h0);

        // Randomized run against the model
        set_in(0,0,0,0,0,0,1); tick();
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 63) != 0);
            pcsrc       = ($urandom_range(0, 7) == 0);
            branch_pc   = $urandom;
            imm_op      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
            if (mem_req) mem_ack = ($urandom_range(0, 1) == 0);
            else         mem_ack = (!instr_valid && $urandom_range(0, 15) == 0);
            mem_rdata   = mem_ack ? (mem_addr ^ 32'hA5A5A5A5) : $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
